// File: rtl/eth_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : eth_pkg
//  Description : Shared Ethernet framing constants, CRC helpers and the
//                receive deframer state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package eth_pkg;

    localparam logic [7:0]  ETH_PRE     = 8'h55;
    localparam logic [7:0]  ETH_SFD     = 8'hD5;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;

    // Bit-reverse a 32-bit word; used to build the LSB-first polynomial.
    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

    localparam logic [31:0] CRC_POLY_REFL = reflect32(CRC_POLY);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_PAYLOAD  = 2'd2,
        ST_DROP     = 2'd3
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/crc32_d8.sv
`default_nettype none
// ============================================================================
//  Module      : crc32_d8
//  Description : Combinational one-byte step of the reflected Ethernet
//                CRC-32 (data consumed LSB first, no inversion).
//  Revision    : 1.0 - initial release
// ============================================================================
module crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    // Eight serial shift/XOR steps, unrolled by synthesis.
    always_comb begin
        logic [31:0] w_c;
        w_c = crc_in;
        for (int i = 0; i < 8; i++) begin
            w_c = (w_c >> 1) ^ ((w_c[0] ^ data[i]) ? CRC_POLY_REFL : 32'h0);
        end
        crc_out = w_c;
    end

endmodule
`default_nettype wire

// File: rtl/gmii_rx_deframer.sv
`default_nettype none
// ============================================================================
//  Module      : gmii_rx_deframer
//  Description : GMII/MII receive deframer. Packs nibbles in 10/100 mode,
//                strips preamble/SFD, checks length and FCS, and streams the
//                payload (FCS removed) with a bad-frame flag on tlast.
//  Revision    : 1.0 - initial release
// ============================================================================
module gmii_rx_deframer
    import eth_pkg::*;
#(
    parameter int MIN_FRAME_LEN = 64,
    parameter int MAX_FRAME_LEN = 1522
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] gmii_rxd,
    input  logic       gmii_rx_dv,
    input  logic       gmii_rx_er,
    input  logic       clk_enable,
    input  logic       mii_select,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    output logic       m_axis_tlast,
    output logic       m_axis_tuser,
    output logic       stat_frame_good,
    output logic       stat_frame_bad,
    output logic       stat_fcs_err,
    output logic       stat_runt,
    output logic       stat_oversize
);

    localparam logic [15:0] c_MIN_LEN = 16'(MIN_FRAME_LEN);
    localparam logic [15:0] c_MAX_LEN = 16'(MAX_FRAME_LEN);
    localparam logic [15:0] c_DLY_LEN = 16'd5;

    logic [7:0]  r_rxd;
    logic        r_dv, r_er, r_ce, r_mii;
    logic        r_phase;
    logic [3:0]  r_lo_nib, r_last_nib;
    rx_state_t   r_state, w_state_nxt;
    logic [31:0] r_crc, w_crc_nxt;
    logic [15:0] r_len, w_len_inc;
    logic [7:0]  r_dly [5];
    logic        r_err;

    logic        w_sfd_realign, w_byte_vld, w_eof;
    logic [7:0]  w_byte;
    logic        w_push, w_start;
    logic        w_crc_bad, w_runt, w_bad;
    logic [7:0]  w_tdata;
    logic        w_tvalid, w_tlast, w_tuser;
    logic        w_good, w_sbad, w_fcs, w_srunt, w_over;

    // Register every GMII input before any decision is made on it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rxd <= '0;
            r_dv  <= 1'b0;
            r_er  <= 1'b0;
            r_ce  <= 1'b0;
            r_mii <= 1'b0;
        end else begin
            r_rxd <= gmii_rxd;
            r_dv  <= gmii_rx_dv;
            r_er  <= gmii_rx_er;
            r_ce  <= clk_enable;
            r_mii <= mii_select;
        end
    end

    // A 5 then D nibble pair before payload is the SFD, whatever the phase.
    assign w_sfd_realign = r_mii && r_ce && r_dv && (r_rxd[3:0] == 4'hD) &&
                           (r_last_nib == 4'h5) &&
                           (r_state == ST_IDLE || r_state == ST_PREAMBLE);
    assign w_byte_vld    = r_ce && r_dv && (!r_mii || r_phase || w_sfd_realign);
    assign w_byte        = !r_mii ? r_rxd :
                           (w_sfd_realign ? ETH_SFD : {r_rxd[3:0], r_lo_nib});
    assign w_eof         = r_ce && !r_dv;

    // Nibble packer state: low nibble first, phase cleared outside carrier.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase    <= 1'b0;
            r_lo_nib   <= '0;
            r_last_nib <= '0;
        end else if (!r_dv) begin
            r_phase    <= 1'b0;
            r_last_nib <= '0;
        end else if (r_ce) begin
            r_last_nib <= r_rxd[3:0];
            if (w_sfd_realign) begin
                r_phase <= 1'b0;
            end else begin
                if (!r_phase) begin
                    r_lo_nib <= r_rxd[3:0];
                end
                r_phase <= ~r_phase;
            end
        end
    end

    crc32_d8 u_crc (
        .crc_in  (r_crc),
        .data    (w_byte),
        .crc_out (w_crc_nxt)
    );

    assign w_len_inc = (r_len == 16'hFFFF) ? r_len : r_len + 16'd1;
    assign w_crc_bad = (r_crc != CRC_RESIDUE);
    assign w_runt    = (r_len < c_MIN_LEN);
    assign w_bad     = r_err || w_crc_bad || w_runt;

    // Next-state, delay-line control and output-beat decode.
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_start     = 1'b0;
        w_tvalid    = 1'b0;
        w_tlast     = 1'b0;
        w_tuser     = 1'b0;
        w_good      = 1'b0;
        w_sbad      = 1'b0;
        w_fcs       = 1'b0;
        w_srunt     = 1'b0;
        w_over      = 1'b0;
        case (r_state)
            ST_IDLE, ST_PREAMBLE: begin
                if (w_byte_vld) begin
                    if (w_byte == ETH_PRE) begin
                        w_state_nxt = ST_PREAMBLE;
                    end else if (w_byte == ETH_SFD) begin
                        w_state_nxt = ST_PAYLOAD;
                        w_start     = 1'b1;
                    end else begin
                        w_state_nxt = ST_DROP;
                    end
                end else if (w_eof && r_state == ST_PREAMBLE) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_PAYLOAD: begin
                if (w_byte_vld) begin
                    w_push = 1'b1;
                    if (r_len >= c_DLY_LEN) begin
                        w_tvalid = 1'b1;
                        if (r_len == c_MAX_LEN) begin
                            w_tlast     = 1'b1;
                            w_tuser     = 1'b1;
                            w_sbad      = 1'b1;
                            w_over      = 1'b1;
                            w_state_nxt = ST_DROP;
                        end
                    end
                end else if (w_eof) begin
                    w_state_nxt = ST_IDLE;
                    if (r_len >= c_DLY_LEN) begin
                        w_tvalid = 1'b1;
                        w_tlast  = 1'b1;
                        w_tuser  = w_bad;
                        w_fcs    = w_crc_bad;
                    end
                    w_sbad  = w_bad;
                    w_good  = !w_bad;
                    w_srunt = w_runt;
                end
            end
            ST_DROP: begin
                if (w_eof) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        w_tdata = w_tvalid ? r_dly[4] : 8'h00;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Frame datapath: CRC, length, error flag and 5-byte FCS delay line.
    always_ff @(posedge clk) begin
        if (rst || w_start) begin
            r_crc <= 32'hFFFFFFFF;
            r_len <= '0;
            r_err <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                r_dly[i] <= '0;
            end
        end else begin
            if (r_state == ST_PAYLOAD && r_ce && r_dv && r_er) begin
                r_err <= 1'b1;
            end
            if (w_push) begin
                r_crc    <= w_crc_nxt;
                r_len    <= w_len_inc;
                r_dly[0] <= w_byte;
                for (int i = 1; i < 5; i++) begin
                    r_dly[i] <= r_dly[i-1];
                end
            end
        end
    end

    // Registered stream and statistics outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_axis_tdata    <= '0;
            m_axis_tvalid   <= 1'b0;
            m_axis_tlast    <= 1'b0;
            m_axis_tuser    <= 1'b0;
            stat_frame_good <= 1'b0;
            stat_frame_bad  <= 1'b0;
            stat_fcs_err    <= 1'b0;
            stat_runt       <= 1'b0;
            stat_oversize   <= 1'b0;
        end else begin
            m_axis_tdata    <= w_tdata;
            m_axis_tvalid   <= w_tvalid;
            m_axis_tlast    <= w_tlast;
            m_axis_tuser    <= w_tuser;
            stat_frame_good <= w_good;
            stat_frame_bad  <= w_sbad;
            stat_fcs_err    <= w_fcs;
            stat_runt       <= w_srunt;
            stat_oversize   <= w_over;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gmii_rx_deframer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gmii_rx_deframer
//  Description : Directed self-checking bench for gmii_rx_deframer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gmii_rx_deframer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] gmii_rxd = '0;
    logic       gmii_rx_dv = 1'b0, gmii_rx_er = 1'b0;
    logic       clk_enable = 1'b1, mii_select = 1'b0;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid, m_axis_tlast, m_axis_tuser;
    logic       stat_frame_good, stat_frame_bad, stat_fcs_err, stat_runt, stat_oversize;

    gmii_rx_deframer #(
        .MIN_FRAME_LEN (64),
        .MAX_FRAME_LEN (64)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .gmii_rxd        (gmii_rxd),
        .gmii_rx_dv      (gmii_rx_dv),
        .gmii_rx_er      (gmii_rx_er),
        .clk_enable      (clk_enable),
        .mii_select      (mii_select),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_tuser    (m_axis_tuser),
        .stat_frame_good (stat_frame_good),
        .stat_frame_bad  (stat_frame_bad),
        .stat_fcs_err    (stat_fcs_err),
        .stat_runt       (stat_runt),
        .stat_oversize   (stat_oversize)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor, sampled on the falling edge.
    logic [7:0] q_data[$];
    logic       q_last[$];
    logic       q_user[$];
    int         q_cyc[$];
    int n_good, n_bad, n_fcs, n_runt, n_over, n_consec, n_last, stat_cyc;
    logic prev_v = 1'b0;

    always @(negedge clk) begin
        if (m_axis_tvalid) begin
            q_data.push_back(m_axis_tdata);
            q_last.push_back(m_axis_tlast);
            q_user.push_back(m_axis_tuser);
            q_cyc.push_back(cyc);
            if (prev_v) n_consec++;
            if (m_axis_tlast) n_last++;
        end
        prev_v = m_axis_tvalid;
        if (stat_frame_good || stat_frame_bad) stat_cyc = cyc;
        n_good += int'(stat_frame_good);
        n_bad  += int'(stat_frame_bad);
        n_fcs  += int'(stat_fcs_err);
        n_runt += int'(stat_runt);
        n_over += int'(stat_oversize);
    end

    task automatic clr();
        q_data.delete(); q_last.delete(); q_user.delete(); q_cyc.delete();
        n_good = 0; n_bad = 0; n_fcs = 0; n_runt = 0; n_over = 0;
        n_consec = 0; n_last = 0; stat_cyc = -1;
    endtask

    // Frame under construction: bytes following the SFD.
    logic [7:0] frm[$];
    int t_b5, t_eof;

    task automatic build_frame(input int n, input bit add_fcs, input bit flip);
        logic [31:0] c;
        frm.delete();
        for (int i = 0; i < n; i++) frm.push_back(8'(i));
        if (add_fcs) begin
            c = 32'hFFFFFFFF;
            foreach (frm[i]) begin
                c = c ^ {24'h0, frm[i]};
                for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            end
            c = ~c;
            frm.push_back(c[7:0]);
            frm.push_back(c[15:8]);
            frm.push_back(c[23:16]);
            frm.push_back(c[31:24]);
            if (flip) frm[n] = frm[n] ^ 8'h01;
        end
    endtask

    task automatic drive(input logic [7:0] d, input logic dv, input logic er, input logic ce);
        @(posedge clk);
        #1;
        gmii_rxd   = d;
        gmii_rx_dv = dv;
        gmii_rx_er = er;
        clk_enable = ce;
    endtask

    task automatic send_byte(input int er_idx);
        mii_select = 1'b0;
        repeat (7) drive(8'h55, 1'b1, 1'b0, 1'b1);
        drive(8'hD5, 1'b1, 1'b0, 1'b1);
        foreach (frm[i]) begin
            drive(frm[i], 1'b1, (i == er_idx), 1'b1);
            if (i == 5) t_b5 = cyc;
        end
        drive(8'h00, 1'b0, 1'b0, 1'b1);
        t_eof = cyc;
        repeat (10) drive(8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic send_nib(input logic [3:0] n);
        drive({4'h0, n}, 1'b1, 1'b0, 1'b1);
        repeat (4) drive({4'h0, n}, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic send_mii();
        mii_select = 1'b1;
        repeat (15) send_nib(4'h5);
        send_nib(4'hD);
        foreach (frm[i]) begin
            send_nib(frm[i][3:0]);
            send_nib(frm[i][7:4]);
        end
        repeat (10) begin
            drive(8'h00, 1'b0, 1'b0, 1'b1);
            repeat (4) drive(8'h00, 1'b0, 1'b0, 1'b0);
        end
        mii_select = 1'b0;
        repeat (4) drive(8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    // Beats must be 0,1,2,... with a single tlast on the final beat.
    task automatic check_frame(input string s, input int n, input logic user);
        check_eq({s, "_nbeats"}, q_data.size(), n);
        check_eq({s, "_nlast"}, n_last, 1);
        if (q_data.size() == n && n > 0) begin
            for (int i = 0; i < n; i++) check_eq({s, "_data"}, {24'h0, q_data[i]}, i);
            check_eq({s, "_tlast"}, {31'h0, q_last[n-1]}, 1);
            check_eq({s, "_tuser"}, {31'h0, q_user[n-1]}, {31'h0, user});
        end
    endtask

    initial begin
        clr();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_outputs",
                 {m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser, stat_frame_good,
                  stat_frame_bad, stat_fcs_err, stat_runt, stat_oversize}, 0);
        rst = 1'b0;
        repeat (4) drive(8'h00, 1'b0, 1'b0, 1'b1);

        // Good 64-byte frame at 1G, with latency checks
        clr(); build_frame(60, 1'b1, 1'b0); send_byte(-1);
        check_frame("good", 60, 1'b0);
        if (q_cyc.size() == 60) begin
            check_eq("first_beat_latency", q_cyc[0], t_b5 + 2);
            check_eq("tlast_latency", q_cyc[59], t_eof + 2);
        end
        check_eq("stat_on_tlast", stat_cyc, t_eof + 2);
        check_eq("good_stat_good", n_good, 1);
        check_eq("good_stat_bad", n_bad, 0);
        check_eq("good_stat_fcs", n_fcs, 0);

        // FCS bit 0 flipped
        clr(); build_frame(60, 1'b1, 1'b1); send_byte(-1);
        check_frame("fcs", 60, 1'b1);
        check_eq("fcs_stat_good", n_good, 0);
        check_eq("fcs_stat_bad", n_bad, 1);
        check_eq("fcs_stat_fcs", n_fcs, 1);

        // rx_er on payload byte 10
        clr(); build_frame(60, 1'b1, 1'b0); send_byte(10);
        check_frame("rxer", 60, 1'b1);
        check_eq("rxer_stat_bad", n_bad, 1);
        check_eq("rxer_stat_fcs", n_fcs, 0);
        check_eq("rxer_stat_good", n_good, 0);

        // MII, enable 1 cycle in 5
        clr(); build_frame(60, 1'b1, 1'b0); send_mii();
        check_frame("mii", 60, 1'b0);
        check_eq("mii_stat_good", n_good, 1);
        check_eq("mii_consec_valid", n_consec, 0);

        // Oversize: 100 bytes with MAX_FRAME_LEN=64
        clr(); build_frame(100, 1'b0, 1'b0); send_byte(-1);
        check_frame("over", 60, 1'b1);
        check_eq("over_stat_over", n_over, 1);
        check_eq("over_stat_bad", n_bad, 1);
        check_eq("over_stat_good", n_good, 0);

        // 4-byte frame: no beats
        clr(); build_frame(4, 1'b0, 1'b0); send_byte(-1);
        check_eq("tiny_nbeats", q_data.size(), 0);
        check_eq("tiny_stat_runt", n_runt, 1);
        check_eq("tiny_stat_bad", n_bad, 1);
        check_eq("tiny_stat_pos", stat_cyc, t_eof + 2);

        // 40-byte frame with correct FCS: runt
        clr(); build_frame(36, 1'b1, 1'b0); send_byte(-1);
        check_frame("runt", 36, 1'b1);
        check_eq("runt_stat_runt", n_runt, 1);
        check_eq("runt_stat_fcs", n_fcs, 0);
        check_eq("runt_stat_bad", n_bad, 1);

        // Reset mid-payload, then a good frame
        clr(); build_frame(60, 1'b1, 1'b0);
        repeat (7) drive(8'h55, 1'b1, 1'b0, 1'b1);
        drive(8'hD5, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) drive(frm[i], 1'b1, 1'b0, 1'b1);
        drive(frm[20], 1'b1, 1'b0, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("pre_reset_valid", {31'h0, m_axis_tvalid}, 1);
        @(negedge clk);
        check_eq("midrst_outputs",
                 {m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser, stat_frame_good,
                  stat_frame_bad, stat_fcs_err, stat_runt, stat_oversize}, 0);
        rst = 1'b0;
        repeat (10) drive(8'h00, 1'b0, 1'b0, 1'b1);
        check_eq("midrst_nlast", n_last, 0);
        check_eq("midrst_stats", n_good + n_bad, 0);
        clr(); send_byte(-1);
        check_frame("after_rst", 60, 1'b0);
        check_eq("after_rst_good", n_good, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: got no completion expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/gmii_rx_deframer.md
# gmii_rx_deframer

Receive-side framing stage placed directly downstream of the RGMII PHY interface, in the `gmii_rx_clk` domain. It consumes the recovered GMII receive bus, packs nibbles in 10/100 mode, strips preamble and SFD, and checks length and FCS. It emits the payload as an 8-bit AXI-stream (FCS removed) with a bad-frame flag on the last beat, plus single-cycle statistics pulses.

## Interface
- `MIN_FRAME_LEN`, 64: minimum legal length in bytes after the SFD, FCS included.
- `MAX_FRAME_LEN`, 1522: maximum legal length in bytes after the SFD, FCS included.
- `clk` in 1: receive clock (`gmii_rx_clk`).
- `rst` in 1: reset; synchronous, active-high.
- `gmii_rxd` in 8: receive data. In MII mode only [3:0] is used.
- `gmii_rx_dv` in 1: receive data valid.
- `gmii_rx_er` in 1: receive error.
- `clk_enable` in 1: qualifies every GMII sample. Tie high at 1G.
- `mii_select` in 1: 1 = nibble (10/100) mode; 0 = byte (1G) mode.
- `m_axis_tdata` out 8: payload byte.
- `m_axis_tvalid` out 1: beat valid. There is no tready; the stream cannot be back-pressured.
- `m_axis_tlast` out 1: last payload byte of a frame.
- `m_axis_tuser` out 1: bad frame. Meaningful only when tlast=1.
- `stat_frame_good` out 1: one-cycle pulse for a good frame.
- `stat_frame_bad` out 1: one-cycle pulse for a bad frame.
- `stat_fcs_err` out 1: one-cycle pulse for an FCS error.
- `stat_runt` out 1: one-cycle pulse for a runt frame.
- `stat_oversize` out 1: one-cycle pulse for an oversize frame.

## Operation
- **Input stage.** All GMII inputs are registered. Only samples with `clk_enable`=1 are processed.
- **MII packing.**
  - Nibbles are packed low nibble first; one byte is produced every second enabled sample.
  - The nibble phase is cleared while `gmii_rx_dv`=0.
  - In IDLE/PREAMBLE, a nibble 0xD that follows a 0x5 is treated as the SFD byte, and the phase realigns there. This tolerates odd preamble nibble counts.
- **FSM states.**
  - IDLE: on dv=1, byte 0x55 → PREAMBLE; byte 0xD5 → PAYLOAD; any other byte → DROP. A sample with dv=0 and er=1 (false carrier) is ignored.
  - PREAMBLE: 0x55 → stay; 0xD5 → PAYLOAD; other → DROP; dv=0 → IDLE.
  - PAYLOAD: each byte is fed to CRC-32 and pushed into a 5-deep delay line, and the length counter increments.
    - On the 6th and later pushes, the oldest byte is emitted with tlast=0.
    - When dv falls, the frame ends → IDLE.
  - DROP: emits nothing; waits for dv=0 → IDLE.
- **End of frame.**
  - After dv falls, the delay line holds the last payload byte plus 4 FCS bytes. The last payload byte is emitted with tlast=1.
  - tuser=1 if any of these hold:
    - `gmii_rx_er` was seen in PAYLOAD;
    - the CRC residue ≠ 0xDEBB20E3;
    - length < `MIN_FRAME_LEN`.
  - Exactly one stat pulse fires: good or bad, plus fcs_err and/or runt when they apply.
- **Length < 5.** No beats are emitted, and `stat_frame_bad` and `stat_runt` pulse.
- **Oversize.** When byte `MAX_FRAME_LEN`+1 is pushed, the oldest byte is emitted with tlast=1, tuser=1. `stat_frame_bad` and `stat_oversize` pulse, and the FSM goes to DROP.
- **CRC.** Reflected CRC-32 (poly 0x04C11DB7), initialised to 0xFFFFFFFF at the SFD. No final inversion before the residue compare.
- **Length counter.** 16 bits, saturating.

## Timing
- Reset (a `rst`=1 cycle): all outputs 0 on the following edge. FSM → IDLE, delay line and counters cleared. A frame in progress is abandoned without a tlast beat.
- Byte mode: byte k is on `m_axis` 2 cycles after byte k+5 is presented on `gmii_rxd`.
- End of frame: tlast is asserted 2 cycles after the first enabled sample with dv=0.
- Stat pulses coincide with the tlast beat. For frames shorter than 5 bytes, they occur in the same position tlast would have.
- MII mode: output beats are separated by at least 2 enabled samples. tvalid is never high for 2 consecutive cycles unless `clk_enable` is constantly 1.
- dv falling in the same enabled sample as the oversize push: the oversize handling wins, and no second tlast is emitted.

## Structure
- A shared package `eth_pkg` holds:
  - constants ETH_PRE=8'h55, ETH_SFD=8'hD5, CRC_RESIDUE=32'hDEBB20E3, CRC_POLY;
  - the FSM state enum.
- Sub-module `crc32_d8`: combinational, one-byte CRC-32 step (crc_in, data → crc_out). It is reusable by the TX framer.

## Test plan
- 1G, 7×0x55+0xD5, payload 0x00..0x3B, correct FCS → 60 beats 0x00..0x3B; tlast on 0x3B with tuser=0; `stat_frame_good`=1 once.
- Same frame with FCS bit 0 flipped → same 60 beats; tuser=1; `stat_frame_bad` and `stat_fcs_err` pulse.
- `gmii_rx_er`=1 on payload byte 10 → tuser=1 on last beat; `stat_frame_bad` pulse, no `stat_fcs_err`.
- MII mode with `clk_enable` high 1 cycle in 5, 15-nibble preamble + 0xD + the same frame → beats identical to the first scenario; tuser=0.
- `MAX_FRAME_LEN`=64, 100-byte frame → 60 beats, the last with tlast=1 and tuser=1; `stat_oversize` pulse; nothing further until the next SFD.
- A 4-byte frame → no beats, `stat_runt`. A 40-byte frame → 36 beats with tuser=1. `rst` mid-payload → outputs 0 next cycle, and the next frame is received correctly.
